// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: datapath hazard sources in,
// per-latch enables/flushes, PC select and counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  logic [4:0]       rd_EX;
  logic             MemRead_EX;
  logic             branch_taken_EX;
  logic [3:0]       exp_vector_MEM;
  logic             mem_req_MEM;
  logic             mem_ack;
  logic             EN_PC;
  logic             EN_IFID;
  logic             EN_IDEX;
  logic             EN_EXMEM;
  logic             EN_MEMWB;
  logic             flush_IFID;
  logic             flush_IDEX;
  logic             flush_EXMEM;
  logic             flush_MEMWB;
  logic [1:0]       pc_sel;
  logic             trap_taken;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
    output rd_EX, MemRead_EX, branch_taken_EX,
    output exp_vector_MEM, mem_req_MEM, mem_ack,
    input  EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB,
    input  flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
    input  pc_sel, trap_taken, bus_err,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
    input  rd_EX, MemRead_EX, branch_taken_EX,
    input  exp_vector_MEM, mem_req_MEM, mem_ack,
    output EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB,
    output flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
    output pc_sel, trap_taken, bus_err,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard sequencer: stall, squash, mem freeze, trap.
// Optional perf counters built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TRAP_LAT    = 2,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TRAP
  } state_t;

  localparam logic [7:0] W_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [3:0] T_INIT = 4'(TRAP_LAT - 1);

  state_t     state;
  logic [7:0] wcnt;
  logic [3:0] tcnt;

  logic run, mw, exc, tmo, frz, dec, br, luh, lu;
  logic mstall;
  logic [4:0] en;
  logic [3:0] fl;
  logic [1:0] psel;
  logic trap, berr;

  always_comb begin
    lu = hz.MemRead_EX && (hz.rd_EX != 5'd0) &&
         ((hz.rs1_used_ID && hz.rs1_ID == hz.rd_EX) ||
          (hz.rs2_used_ID && hz.rs2_ID == hz.rd_EX));
    run    = (state == RUN);
    mw     = (state == MEM_WAIT);
    mstall = hz.mem_req_MEM && !hz.mem_ack;
    exc    = run && (hz.exp_vector_MEM != 4'd0);
    tmo    = mw && !hz.mem_ack && (wcnt == W_LAST);
    frz    = (run && !exc && mstall) ||
             (mw && !hz.mem_ack && !tmo);
    // ack cycle of a wait resolves like a normal RUN cycle
    dec    = (run && !exc && !mstall) || (mw && hz.mem_ack);
    br     = dec && hz.branch_taken_EX;
    luh    = dec && !hz.branch_taken_EX && lu;
  end

  always_comb begin
    en   = 5'b11111;
    fl   = 4'b0000;
    psel = 2'd0;
    trap = 1'b0;
    berr = 1'b0;
    unique case (1'b1)
      (state == TRAP): begin
        en[4] = 1'b0;
        fl[3] = 1'b1;
      end
      (exc || tmo): begin
        fl   = 4'b1111;
        psel = 2'd2;
        trap = 1'b1;
        berr = tmo;
      end
      frz: begin
        en = 5'b00001;
        fl = 4'b0001;
      end
      br: begin
        fl   = 4'b1100;
        psel = 2'd1;
      end
      luh: begin
        en[4] = 1'b0;
        en[3] = 1'b0;
        fl[2] = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.EN_PC       = en[4];
  assign hz.EN_IFID     = en[3];
  assign hz.EN_IDEX     = en[2];
  assign hz.EN_EXMEM    = en[1];
  assign hz.EN_MEMWB    = en[0];
  assign hz.flush_IFID  = fl[3];
  assign hz.flush_IDEX  = fl[2];
  assign hz.flush_EXMEM = fl[1];
  assign hz.flush_MEMWB = fl[0];
  assign hz.pc_sel      = psel;
  assign hz.trap_taken  = trap;
  assign hz.bus_err     = berr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
      tcnt  <= 4'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (exc) begin
            state <= TRAP;
            tcnt  <= T_INIT;
          end else if (mstall) begin
            state <= MEM_WAIT;
            wcnt  <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ack) begin
            state <= RUN;
            wcnt  <= 8'd0;
          end else if (tmo) begin
            state <= TRAP;
            wcnt  <= 8'd0;
            tcnt  <= T_INIT;
          end else if (wcnt != W_LAST) begin
            wcnt <= wcnt + 8'd1;
          end
        end
        TRAP: begin
          if (tcnt == 4'd0) state <= RUN;
          else tcnt <= tcnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en[4]) stall_q <= stall_q + CNT_W'(1);
      if (psel == 2'd1 || trap)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Generates every per-stage EN and flush: load-use stall, taken-branch squash, data-memory wait freeze, and exception drain/redirect with a fixed trap latency.
- Sits beside the datapath. Its outputs drive the EN/flush inputs of each pipeline latch and the PC mux select.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ack before a bus error; range 2..255.
- TRAP_LAT, 2: cycles the PC is held after a trap is taken (CSR update window); range 1..15.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID
- rs1_used_ID, rs2_used_ID  in  1 each  source actually read
- rd_EX  in  5  destination register of the instruction in EX
- MemRead_EX  in  1  EX instruction is a load
- branch_taken_EX  in  1  EX resolved a taken branch/jump
- exp_vector_MEM  in  4  exception code in MEM; 0 = none
- mem_req_MEM  in  1  MEM instruction accesses data memory
- mem_ack  in  1  data memory completes this cycle
- EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB  out  1 each  latch enables
- flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB  out  1 each  bubble insert (meaningful only with EN=1)
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = trap vector
- trap_taken  out  1  one-cycle pulse: exception accepted
- bus_err  out  1  one-cycle pulse: memory timeout
- stall_cycles, flush_events  out  CNT_W each  performance counters

Behaviour:
- FSM states: RUN, MEM_WAIT, TRAP. Registers: state, wcnt (8b), tcnt (4b).
- All EN/flush/pc_sel/pulse outputs are combinational from state and inputs.
- Default (RUN, no event): all EN=1, all flush=0, pc_sel=0.
- Reset (rst=0): state=RUN, wcnt=0, tcnt=0, counters=0. Outputs therefore take the RUN defaults, trap_taken=0, bus_err=0.
- RUN priority, highest first:
  - Exception: exp_vector_MEM!=0. All EN=1; flush_IFID/IDEX/EXMEM/MEMWB=1; pc_sel=2; trap_taken=1; next=TRAP, tcnt=TRAP_LAT-1. mem_req_MEM is ignored in this cycle.
  - Memory wait: mem_req_MEM && !mem_ack. EN_PC=EN_IFID=EN_IDEX=EN_EXMEM=0; EN_MEMWB=1, flush_MEMWB=1, so the WB instruction retires once and a bubble follows. next=MEM_WAIT, wcnt=1.
  - Branch: branch_taken_EX. flush_IFID=1, flush_IDEX=1, pc_sel=1. Branch overrides load-use, since the ID instruction is wrong-path.
  - Load-use: MemRead_EX && rd_EX!=0 && ((rs1_used_ID && rs1_ID==rd_EX) || (rs2_used_ID && rs2_ID==rd_EX)). EN_PC=0, EN_IFID=0, flush_IDEX=1; exactly one bubble.
- MEM_WAIT:
  - Freeze as above every cycle; wcnt increments.
  - mem_ack=1: this cycle behaves as RUN with mem_ack high (all EN=1), next=RUN. ack and timeout in the same cycle: ack wins.
  - wcnt==MEM_TIMEOUT-1 && !mem_ack: bus_err=1 and trap actions (all flushes, pc_sel=2, trap_taken=1), next=TRAP.
  - An exception arriving while in MEM_WAIT is ignored; the MEM instruction is frozen and its exp_vector was checked on entry.
- TRAP:
  - EN_PC=0, EN_IFID=1 with flush_IFID=1; all other EN=1, flush=0; pc_sel=0.
  - tcnt decrements; at tcnt==0, next=RUN.
  - branch_taken_EX and the load-use check are ignored (pipeline holds only bubbles).
- Reset mid-wait or mid-trap: immediate return to RUN, counters cleared.
- Widths: rs/rd compares are 5-bit; rd_EX==0 never stalls. wcnt saturates at MEM_TIMEOUT-1.

Optional Feature:
- Macro HAZ_PERF_CNT_EN. Defined:
  - stall_cycles increments every cycle with EN_PC=0 outside reset.
  - flush_events increments on each branch squash or trap_taken.
  - Both wrap modulo 2^CNT_W.
- Undefined: both outputs tied to 0 and no counter flops are built.

Test Plan:
- Load-use: lw x5 in EX (MemRead_EX=1, rd_EX=5), ID has rs2_ID=5, rs2_used_ID=1 -> exactly 1 cycle with EN_PC=0, EN_IFID=0, flush_IDEX=1; next cycle all EN=1. Same case with rd_EX=0 -> no stall.
- Branch plus load-use in the same cycle -> flush_IFID=flush_IDEX=1, pc_sel=1, EN_PC=1 (no stall).
- Memory wait: mem_req_MEM=1, mem_ack arrives 3 cycles later -> 3 cycles with EN_EXMEM=0 and flush_MEMWB=1, then all EN=1 and state RUN.
- Timeout: mem_req_MEM=1, no ack, MEM_TIMEOUT=16 -> bus_err and trap_taken pulse together 15 cycles after entering MEM_WAIT, pc_sel=2, then 2 TRAP cycles with EN_PC=0.
- Exception: exp_vector_MEM=4'h2 with mem_req_MEM=1 and branch_taken_EX=1 -> all four flushes, pc_sel=2, no MEM_WAIT entry; EN_PC=0 for TRAP_LAT=2 cycles, then RUN.
- Reset: drop rst low in MEM_WAIT cycle 2 -> state RUN, all EN=1, counters 0; with HAZ_PERF_CNT_EN, 5 load-use stalls plus 2 branches -> stall_cycles=5, flush_events=2.
